// File: rtl/riscv_scoreboard_hazard_unit.sv
// Scoreboard hazard unit: tracks pending destinations of variable-latency instructions,
// stalls ID on RAW/WAW against them, and raises control-flow flushes.
module riscv_scoreboard_hazard_unit #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned WB_PORTS = 2,
    parameter int unsigned CNT_W    = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [ADDR_W-1:0]          id_rs1_addr,
    input  logic [ADDR_W-1:0]          id_rs2_addr,
    input  logic                       id_uses_rs1,
    input  logic                       id_uses_rs2,
    input  logic [ADDR_W-1:0]          id_rd_addr,
    input  logic                       id_writes_rd,
    input  logic                       id_long_lat,
    input  logic [WB_PORTS-1:0]        wb_valid,
    input  logic [WB_PORTS*ADDR_W-1:0] wb_rd_addr,
    input  logic                       branch_taken,
    input  logic                       jump,
    output logic                       stall,
    output logic                       flush_if_id,
    output logic                       flush_id_ex,
    output logic [NUM_REGS-1:0]        pending,
    output logic [CNT_W-1:0]           pending_count,
    output logic                       busy
);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [NUM_REGS-1:0] clr, eff, rd_sel;
    logic                rs1_hit, rs2_hit, rd_hit;
    logic                raw, waw, redirect, issue;

    // Register 0 and out-of-range addresses never decode, so they are neither set nor cleared.
    always_comb begin
        clr = '0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            for (int unsigned p = 0; p < WB_PORTS; p++) begin
                if (wb_valid[p] && (wb_rd_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
                    clr[r] = 1'b1;
                end
            end
        end
    end

    // Write-through register file: a same-cycle clear already hides the hazard.
    assign eff = pending_q & ~clr;

    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        rd_hit  = 1'b0;
        rd_sel  = '0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            if (id_rs1_addr == ADDR_W'(r) && eff[r]) rs1_hit = 1'b1;
            if (id_rs2_addr == ADDR_W'(r) && eff[r]) rs2_hit = 1'b1;
            if (id_rd_addr == ADDR_W'(r)) begin
                rd_sel[r] = 1'b1;
                if (eff[r]) rd_hit = 1'b1;
            end
        end
    end

    assign raw      = id_valid & ((id_uses_rs1 & rs1_hit) | (id_uses_rs2 & rs2_hit));
    assign waw      = id_valid & id_writes_rd & rd_hit;
    assign redirect = branch_taken | jump;
    assign issue    = id_valid & id_writes_rd & id_long_lat & (|rd_sel) & ~raw & ~waw & ~redirect;

    assign stall       = (raw | waw) & ~redirect;
    assign flush_if_id = redirect;
    assign flush_id_ex = redirect | raw | waw;

    // OR-ing the set after the clear lets a new issue win over a retire of the same register.
    always_comb begin
        pending_d = (pending_q & ~clr) | (issue ? rd_sel : '0);
        count_d   = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            count_d = count_d + CNT_W'(pending_d[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    assign pending       = pending_q;
    assign pending_count = count_q;
    assign busy          = (count_q != '0);

endmodule

// File: tb/tb_riscv_scoreboard_hazard_unit.sv
// Self-checking bench for riscv_scoreboard_hazard_unit: directed scenarios plus
// randomized traffic against a set-based scoreboard model.
module tb_riscv_scoreboard_hazard_unit;

    localparam int NR = 32;
    localparam int AW = 5;
    localparam int WP = 2;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_uses_rs1, id_uses_rs2, id_writes_rd, id_long_lat;
    logic [AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [WP-1:0] wb_valid;
    logic [WP*AW-1:0] wb_rd_addr;
    logic          branch_taken, jump;
    logic          stall, flush_if_id, flush_id_ex, busy;
    logic [NR-1:0] pending;
    logic [CW-1:0] pending_count;

    int checks = 0;
    int errors = 0;

    // Model: the set of register numbers currently awaiting writeback.
    bit in_flight[NR];

    riscv_scoreboard_hazard_unit #(
        .NUM_REGS(NR), .ADDR_W(AW), .WB_PORTS(WP), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd_addr(id_rd_addr), .id_writes_rd(id_writes_rd), .id_long_lat(id_long_lat),
        .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr),
        .branch_taken(branch_taken), .jump(jump),
        .stall(stall), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .pending(pending), .pending_count(pending_count), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic bit retiring(int r);
        for (int p = 0; p < WP; p++)
            if (wb_valid[p] && int'(wb_rd_addr[p*AW +: AW]) == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit blocked(int r);
        return r != 0 && r < NR && in_flight[r] && !retiring(r);
    endfunction

    function automatic bit m_raw();
        return id_valid && ((id_uses_rs1 && blocked(int'(id_rs1_addr))) ||
                            (id_uses_rs2 && blocked(int'(id_rs2_addr))));
    endfunction

    function automatic bit m_waw();
        return id_valid && id_writes_rd && blocked(int'(id_rd_addr));
    endfunction

    function automatic bit m_issue();
        return id_valid && id_writes_rd && id_long_lat && id_rd_addr != 0 &&
               int'(id_rd_addr) < NR && !m_raw() && !m_waw() && !branch_taken && !jump;
    endfunction

    function automatic logic [NR-1:0] m_vec();
        logic [NR-1:0] v = '0;
        for (int r = 0; r < NR; r++) if (in_flight[r]) v[r] = 1'b1;
        return v;
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int r = 0; r < NR; r++) n += int'(in_flight[r]);
        return n;
    endfunction

    task automatic drive_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                            input int rd, input bit w, input bit ll);
        id_valid = v; id_rs1_addr = AW'(rs1); id_uses_rs1 = u1;
        id_rs2_addr = AW'(rs2); id_uses_rs2 = u2;
        id_rd_addr = AW'(rd); id_writes_rd = w; id_long_lat = ll;
    endtask

    task automatic drive_wb(input bit v0, input int a0, input bit v1, input int a1);
        wb_valid = {v1, v0};
        wb_rd_addr = {AW'(a1), AW'(a0)};
    endtask

    task automatic idle();
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
        drive_wb(0, 0, 0, 0);
        branch_taken = 1'b0; jump = 1'b0; rst = 1'b0;
        #1;
    endtask

    // Advance one clock and update the model from the inputs held during that cycle.
    task automatic tick();
        bit iss, rs;
        int rd;
        bit clr_now[NR];
        iss = m_issue();
        rs  = rst;
        rd  = int'(id_rd_addr);
        for (int r = 0; r < NR; r++) clr_now[r] = retiring(r);
        @(posedge clk);
        if (rs) begin
            for (int r = 0; r < NR; r++) in_flight[r] = 1'b0;
        end else begin
            for (int r = 1; r < NR; r++) if (clr_now[r]) in_flight[r] = 1'b0;
            if (iss) in_flight[rd] = 1'b1;
        end
        #1;
    endtask

    task automatic issue_long(input int rd);
        idle();
        drive_id(1, 0, 0, 0, 0, rd, 1, 1);
        #1;
        tick();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        idle();
        checks += 6;
        if (pending !== '0) begin errors++; $display("FAIL reset_pending got %h exp 0", pending); end
        if (pending_count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", pending_count); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
        if (flush_if_id !== 1'b0) begin errors++; $display("FAIL reset_fifd got %b exp 0", flush_if_id); end
        if (flush_id_ex !== 1'b0) begin errors++; $display("FAIL reset_fidex got %b exp 0", flush_id_ex); end
    endtask

    task automatic test_load_use();
        issue_long(5);
        idle();
        drive_id(1, 5, 1, 0, 0, 0, 0, 0);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks += 2;
            if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall[%0d] got %b exp 1", i, stall); end
            if (flush_id_ex !== 1'b1) begin errors++; $display("FAIL lu_fidex[%0d] got %b exp 1", i, flush_id_ex); end
            tick();
        end
        drive_wb(1, 5, 0, 0);
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL lu_release got %b exp 0", stall); end
        tick();
        idle();
        checks++;
        if (pending[5] !== 1'b0) begin errors++; $display("FAIL lu_cleared got %b exp 0", pending[5]); end
    endtask

    task automatic test_dual_retire();
        issue_long(3);
        issue_long(7);
        idle();
        checks += 2;
        if (pending !== 32'h0000_0088) begin errors++; $display("FAIL dr_pending got %h exp 00000088", pending); end
        if (pending_count !== 6'd2) begin errors++; $display("FAIL dr_count got %0d exp 2", pending_count); end
        drive_wb(1, 3, 1, 7);
        #1;
        tick();
        idle();
        checks += 2;
        if (pending !== '0) begin errors++; $display("FAIL dr_after got %h exp 0", pending); end
        if (busy !== 1'b0) begin errors++; $display("FAIL dr_busy got %b exp 0", busy); end
    endtask

    task automatic test_waw_setclear();
        issue_long(9);
        idle();
        drive_id(1, 0, 0, 0, 0, 9, 1, 1);
        drive_wb(0, 0, 1, 9);
        #1;
        checks += 2;
        if (stall !== 1'b0) begin errors++; $display("FAIL waw_stall got %b exp 0", stall); end
        if (flush_id_ex !== 1'b0) begin errors++; $display("FAIL waw_fidex got %b exp 0", flush_id_ex); end
        tick();
        idle();
        checks += 2;
        if (pending[9] !== 1'b1) begin errors++; $display("FAIL waw_bit9 got %b exp 1", pending[9]); end
        if (pending_count !== 6'd1) begin errors++; $display("FAIL waw_count got %0d exp 1", pending_count); end
        // Plain WAW against a still-pending register must stall.
        drive_id(1, 0, 0, 0, 0, 9, 1, 0);
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL waw_hazard got %b exp 1", stall); end
        idle();
        drive_wb(1, 9, 0, 0);
        #1;
        tick();
    endtask

    task automatic test_x0();
        issue_long(12);
        idle();
        drive_id(1, 0, 1, 12, 0, 0, 0, 0);
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL x0_stall got %b exp 0", stall); end
        drive_id(1, 0, 1, 12, 0, 0, 1, 1);
        #1;
        tick();
        idle();
        checks++;
        if (pending !== 32'h0000_1000) begin errors++; $display("FAIL x0_pending got %h exp 00001000", pending); end
        drive_wb(1, 12, 0, 0);
        #1;
        tick();
    endtask

    task automatic test_redirect();
        issue_long(4);
        idle();
        drive_id(1, 4, 1, 0, 0, 6, 1, 1);
        branch_taken = 1'b1;
        #1;
        checks += 3;
        if (stall !== 1'b0) begin errors++; $display("FAIL rd_stall got %b exp 0", stall); end
        if (flush_if_id !== 1'b1) begin errors++; $display("FAIL rd_fifd got %b exp 1", flush_if_id); end
        if (flush_id_ex !== 1'b1) begin errors++; $display("FAIL rd_fidex got %b exp 1", flush_id_ex); end
        tick();
        idle();
        checks++;
        if (pending !== 32'h0000_0010) begin errors++; $display("FAIL rd_pending got %h exp 00000010", pending); end
        drive_wb(1, 4, 0, 0);
        #1;
        tick();
    endtask

    task automatic test_reset_midflight();
        for (int r = 1; r <= 4; r++) issue_long(r);
        idle();
        checks++;
        if (pending_count !== 6'd4) begin errors++; $display("FAIL rm_count_pre got %0d exp 4", pending_count); end
        rst = 1'b1;
        drive_wb(1, 1, 1, 2);
        drive_id(1, 0, 0, 0, 0, 8, 1, 1);
        #1;
        tick();
        idle();
        checks += 3;
        if (pending !== '0) begin errors++; $display("FAIL rm_pending got %h exp 0", pending); end
        if (pending_count !== '0) begin errors++; $display("FAIL rm_count got %0d exp 0", pending_count); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b exp 0", busy); end
    endtask

    function automatic int rnd_addr();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
    endfunction

    task automatic test_random();
        bit e_raw, e_waw, e_redir;
        for (int i = 0; i < 600; i++) begin
            drive_id($urandom_range(0, 3) != 0, rnd_addr(), 1'($urandom), rnd_addr(), 1'($urandom),
                     rnd_addr(), 1'($urandom), 1'($urandom));
            drive_wb($urandom_range(0, 1) == 0, rnd_addr(), $urandom_range(0, 2) == 0, rnd_addr());
            branch_taken = ($urandom_range(0, 9) == 0);
            jump = ($urandom_range(0, 14) == 0);
            rst = ($urandom_range(0, 79) == 0);
            #1;
            e_raw = m_raw();
            e_waw = m_waw();
            e_redir = branch_taken || jump;
            checks += 3;
            if (stall !== ((e_raw || e_waw) && !e_redir)) begin
                errors++; $display("FAIL rnd_stall[%0d] got %b exp %b", i, stall, (e_raw || e_waw) && !e_redir);
            end
            if (flush_if_id !== e_redir) begin
                errors++; $display("FAIL rnd_fifd[%0d] got %b exp %b", i, flush_if_id, e_redir);
            end
            if (flush_id_ex !== (e_redir || e_raw || e_waw)) begin
                errors++; $display("FAIL rnd_fidex[%0d] got %b exp %b", i, flush_id_ex, e_redir || e_raw || e_waw);
            end
            tick();
            checks += 3;
            if (pending !== m_vec()) begin
                errors++; $display("FAIL rnd_pending[%0d] got %h exp %h", i, pending, m_vec());
            end
            if (int'(pending_count) !== m_count()) begin
                errors++; $display("FAIL rnd_count[%0d] got %0d exp %0d", i, pending_count, m_count());
            end
            if (busy !== (m_count() != 0)) begin
                errors++; $display("FAIL rnd_busy[%0d] got %b exp %b", i, busy, m_count() != 0);
            end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_dual_retire();
        test_waw_setclear();
        test_x0();
        test_redirect();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_scoreboard_hazard_unit.md
# riscv_scoreboard_hazard_unit

Parametrised scoreboard hazard unit for the RISC-V pipeline, placed between ID and the issue into ID/EX. It tracks destination registers of in-flight variable-latency instructions (loads, multi-cycle mul/div) in a per-register pending scoreboard. It stalls ID on RAW and WAW hazards against that scoreboard and generates control-flow flushes. Multiple writeback ports retire pending entries, so a single fixed load-use window no longer covers every hazard.

## Interface
- `NUM_REGS`, 32: architectural registers; register 0 is never tracked.
- `ADDR_W`, 5: register address width; `2**ADDR_W >= NUM_REGS`.
- `WB_PORTS`, 2: number of independent writeback/completion ports.
- `CNT_W`, 6: width of `pending_count`; must hold `NUM_REGS-1`.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  ID holds a valid instruction.
- `id_rs1_addr`, `id_rs2_addr`  in  ADDR_W  ID source registers.
- `id_uses_rs1`, `id_uses_rs2`  in  1  source actually read.
- `id_rd_addr`  in  ADDR_W  ID destination register.
- `id_writes_rd`  in  1  instruction writes rd.
- `id_long_lat`  in  1  instruction completes through a writeback port (load, mul, div).
- `wb_valid`  in  WB_PORTS  per-port completion strobe.
- `wb_rd_addr`  in  WB_PORTS*ADDR_W  per-port completing rd, port p at `[p*ADDR_W +: ADDR_W]`.
- `branch_taken`, `jump`  in  1  resolved control-flow redirect from EX.
- `stall`  out  1  freeze PC and IF/ID; bubble into ID/EX.
- `flush_if_id`  out  1  squash IF/ID.
- `flush_id_ex`  out  1  insert bubble into ID/EX.
- `pending`  out  NUM_REGS  scoreboard bits; bit 0 is constant 0.
- `pending_count`  out  CNT_W  population count of `pending`.
- `busy`  out  1  `pending_count != 0`.

## Operation
- `clr[r]` = OR over ports p of `wb_valid[p] & (wb_rd_addr_p == r)`, for r != 0.
- `eff[r]` = `pending[r] & ~clr[r]`. This is the same-cycle view used for hazard checks, because the register file is write-through.
- `raw` = `id_valid & ((id_uses_rs1 & rs1 != 0 & eff[rs1]) | (id_uses_rs2 & rs2 != 0 & eff[rs2]))`.
- `waw` = `id_valid & id_writes_rd & rd != 0 & eff[rd]`.
- `redirect` = `branch_taken | jump`.
- `stall` = `(raw | waw) & ~redirect`. A redirect squashes the ID instruction, so no stall is raised during a redirect.
- `flush_if_id` = `redirect`.
- `flush_id_ex` = `redirect | raw | waw`.
- `issue` = `id_valid & id_writes_rd & id_long_lat & id_rd_addr != 0 & ~raw & ~waw & ~redirect`.
- Next state per register r:
  - `pending[r] <= (pending[r] & ~clr[r]) | (issue & id_rd_addr == r)`.
  - A set wins over a clear to the same register in the same cycle.
- `pending_count` is registered alongside `pending`, so it always equals `popcount(pending)`.
- Addresses at or above `NUM_REGS` are ignored for both set and clear, and never match any source.
- A writeback to a register that is not pending is a no-op, not an error.
- Two ports clearing the same register in one cycle is equivalent to a single clear.
- The scoreboard is not cleared by redirects. Instructions already past ID still complete and retire through the writeback ports.

## Timing
- Reset: `pending`=0, `pending_count`=0, `busy`=0. Combinational outputs follow their inputs: with idle inputs, `stall`=`flush_if_id`=`flush_id_ex`=0.
- `rst` asserted mid-operation clears every pending bit on that edge. Writebacks and issue in the same cycle are ignored.
- `stall`, `flush_if_id` and `flush_id_ex` are combinational with zero latency.
- A scoreboard bit set at edge N is visible to the ID instruction in cycle N+1. This is the load-use case: an issuing load forces a one-cycle-minimum stall on a dependent consumer that follows directly.
- A clear takes effect in the same cycle as `wb_valid`. A consumer waiting on the cleared register drops `stall` in that cycle and issues.
- Stall duration is unbounded and tracks the producer's completion. There is no timeout.

## Test plan
- Load-use: issue long-lat with rd=5; next cycle ID reads rs1=5 → `stall`=1 and `flush_id_ex`=1 until `wb_valid[0]` with rd=5; in that cycle `stall`=0; `pending[5]` reads 0 after the edge.
- Dual-port retire: pending {3,7}, `pending_count`=2; `wb_valid`=2'b11 with rd 3 and 7 → `pending`=0, `busy`=0 next cycle.
- WAW plus simultaneous set/clear: x9 pending; ID long-lat writing rd=9, no sources, while port 1 retires 9 → no stall, `issue`; `pending[9]`=1 afterwards, count unchanged at 1.
- x0 and unused sources: ID rs1=0 with `id_uses_rs2`=0 and rs2 pending → `stall`=0; long-lat rd=0 → `pending` stays 0.
- Redirect priority: RAW hazard present with `branch_taken`=1 → `stall`=0, `flush_if_id`=1, `flush_id_ex`=1, no new pending bit; existing bits retained.
- Reset mid-flight: 4 registers pending, `rst`=1 together with `wb_valid` → all outputs return to reset values next cycle.
